// File: rtl/ts_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ts_packet_fifo
// Description : Single-clock packet-aware FIFO for MPEG-2 TS byte streams.
//               Bytes are written speculatively and only become readable once
//               the packet's last byte is accepted without error. Errored,
//               overflowed or explicitly dropped packets are discarded
//               atomically by rolling the speculative write pointer back.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   single clock for write and read sides
//   rst        in   asynchronous active-high reset
//   wen        in   write request
//   wdata      in   write byte
//   wlast      in   last byte of packet (qualified by wen)
//   wdrop      in   discard packet in progress (with or without wen)
//   wfull      out  speculative occupancy == depth
//   wafull     out  speculative occupancy >= AF_LEVEL
//   drop_pulse out  one-cycle pulse after a rollback
//   ren        in   read request
//   rdata      out  registered read byte
//   rlast      out  registered last flag stored with rdata
//   rvalid     out  high the cycle after an accepted read
//   rempty     out  no committed data
//   level      out  committed occupancy
//   pkt_count  out  committed packets not yet fully read
// ============================================================================
module ts_packet_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 188
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  input  logic                  wdrop,
  output logic                  wfull,
  output logic                  wafull,
  output logic                  drop_pulse,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rlast,
  output logic                  rvalid,
  output logic                  rempty,
  output logic [ADDR_WIDTH:0]   level,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AF_THRESH = AF_LEVEL[ADDR_WIDTH:0];

  // Each entry holds {last flag, data byte}
  logic [DATA_WIDTH:0] mem [0:(1 << ADDR_WIDTH)-1];

  logic [ADDR_WIDTH:0] wptr_spec;
  logic [ADDR_WIDTH:0] wptr_cmt;
  logic [ADDR_WIDTH:0] rptr;
  logic                pkt_err;

  logic [ADDR_WIDTH:0] spec_occ;
  logic [DATA_WIDTH:0] rd_word;
  logic                we;
  logic                re;
  logic                commit;
  logic                rollback;
  logic                last_read;

  // Flags decode registered pointers only; the wrap bit disambiguates
  // full from empty when the low address bits match.
  assign spec_occ = wptr_spec - rptr;
  assign wfull    = (spec_occ == DEPTH);
  assign wafull   = (spec_occ >= AF_THRESH);
  assign rempty   = (wptr_cmt == rptr);
  assign level    = wptr_cmt - rptr;

  assign we       = wen & ~wfull & ~wdrop;
  assign re       = ren & ~rempty;
  assign rd_word  = mem[rptr[ADDR_WIDTH-1:0]];

  // A poisoned packet is never committed: its last byte triggers rollback
  // instead. commit and rollback are mutually exclusive since commit
  // requires we (no wdrop, not full) and a clean packet.
  assign commit    = we & wlast & ~pkt_err;
  assign rollback  = wdrop | (wen & wlast & (pkt_err | wfull));
  assign last_read = re & rd_word[DATA_WIDTH];

  // Storage array carries no reset; stale content is unreachable because
  // every pointer returns to zero together.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr_spec[ADDR_WIDTH-1:0]] <= {wlast, wdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_spec  <= '0;
      wptr_cmt   <= '0;
      rptr       <= '0;
      pkt_err    <= 1'b0;
      pkt_count  <= '0;
      rdata      <= '0;
      rlast      <= 1'b0;
      rvalid     <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= rollback;
      rvalid     <= re;

      if (rollback) begin
        wptr_spec <= wptr_cmt;
        pkt_err   <= 1'b0;
      end else begin
        if (we) begin
          wptr_spec <= wptr_spec + PTR_ONE;
        end
        // Overflowed byte is lost; remember that the packet is incomplete
        if (wen & wfull) begin
          pkt_err <= 1'b1;
        end
      end

      if (commit) begin
        wptr_cmt <= wptr_spec + PTR_ONE;
      end

      if (re) begin
        rptr  <= rptr + PTR_ONE;
        rdata <= rd_word[DATA_WIDTH-1:0];
        rlast <= rd_word[DATA_WIDTH];
      end

      // Commit and last-byte read in the same cycle cancel out
      case ({commit, last_read})
        2'b10:   pkt_count <= pkt_count + PTR_ONE;
        2'b01:   pkt_count <= pkt_count - PTR_ONE;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ts_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ts_packet_fifo
// Description : Directed self-checking bench for ts_packet_fifo. A default
//               instance (depth 1024) and a small instance (depth 16) share
//               clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_packet_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Default-size instance
  logic        wen = 1'b0, wlast = 1'b0, wdrop = 1'b0, ren = 1'b0;
  logic [7:0]  wdata = 8'h00;
  logic        wfull, wafull, drop_pulse, rlast, rvalid, rempty;
  logic [7:0]  rdata;
  logic [10:0] level, pkt_count;

  // Small instance (ADDR_WIDTH = 4)
  logic        s_wen = 1'b0, s_wlast = 1'b0, s_wdrop = 1'b0, s_ren = 1'b0;
  logic [7:0]  s_wdata = 8'h00;
  logic        s_wfull, s_wafull, s_drop, s_rlast, s_rvalid, s_rempty;
  logic [7:0]  s_rdata;
  logic [4:0]  s_level, s_pkt_count;

  int checks = 0;
  int errors = 0;

  ts_packet_fifo dut (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .wlast(wlast),
    .wdrop(wdrop), .wfull(wfull), .wafull(wafull), .drop_pulse(drop_pulse),
    .ren(ren), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
    .rempty(rempty), .level(level), .pkt_count(pkt_count)
  );

  ts_packet_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AF_LEVEL(12)) dut_s (
    .clk(clk), .rst(rst), .wen(s_wen), .wdata(s_wdata), .wlast(s_wlast),
    .wdrop(s_wdrop), .wfull(s_wfull), .wafull(s_wafull), .drop_pulse(s_drop),
    .ren(s_ren), .rdata(s_rdata), .rlast(s_rlast), .rvalid(s_rvalid),
    .rempty(s_rempty), .level(s_level), .pkt_count(s_pkt_count)
  );

  always #5 clk = ~clk;

  // Byte patterns: 0 = TS sync byte then 0x00.., 1 and 2 = arbitrary
  function automatic logic [7:0] pat(input int p, input int i);
    case (p)
      0:       pat = (i == 0) ? 8'h47 : 8'(i - 1);
      1:       pat = 8'(i) ^ 8'h5A;
      default: pat = 8'(i * 3 + 1);
    endcase
  endfunction

  function automatic logic [7:0] stream_byte(input int k);
    stream_byte = 8'(k * 7 + 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pkt(input int n, input int p, input bit with_last);
    for (int i = 0; i < n; i++) begin
      wen   = 1'b1;
      wdata = pat(p, i);
      wlast = with_last && (i == n - 1);
      tick();
    end
    wen   = 1'b0;
    wlast = 1'b0;
  endtask

  // Reads n bytes of packets of length len with pattern p, index offset start
  task automatic read_check(input string name, input int n, input int len,
                            input int p, input int start);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = (start + i) % len;
      ren = 1'b1;
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== pat(p, idx) ||
          rlast !== (idx == len - 1)) begin
        errors++;
        $display("FAIL %s byte %0d: rvalid=%b rdata=%h rlast=%b, expected rvalid=1 rdata=%h rlast=%b",
                 name, i, rvalid, rdata, rlast, pat(p, idx), (idx == len - 1));
      end
    end
    ren = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (rempty !== 1'b1 || level !== 11'd0 || pkt_count !== 11'd0 ||
        wfull !== 1'b0 || wafull !== 1'b0 || rvalid !== 1'b0 ||
        rdata !== 8'h00 || rlast !== 1'b0 || drop_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rempty=%b level=%0d pkt=%0d wfull=%b wafull=%b rvalid=%b rdata=%h rlast=%b drop=%b, expected 1,0,0,0,0,0,00,0,0",
               rempty, level, pkt_count, wfull, wafull, rvalid, rdata, rlast, drop_pulse);
    end
    checks++;
    if (s_rempty !== 1'b1 || s_level !== 5'd0 || s_wfull !== 1'b0) begin
      errors++;
      $display("FAIL reset_small: rempty=%b level=%0d wfull=%b, expected 1,0,0",
               s_rempty, s_level, s_wfull);
    end
  endtask

  task automatic test_single_packet();
    write_pkt(187, 0, 1'b0);
    checks++;
    if (rempty !== 1'b1 || level !== 11'd0) begin
      errors++;
      $display("FAIL spec_hidden: rempty=%b level=%0d, expected 1,0", rempty, level);
    end
    wen = 1'b1; wdata = pat(0, 187); wlast = 1'b1;
    tick();
    wen = 1'b0; wlast = 1'b0;
    checks++;
    if (rempty !== 1'b0 || level !== 11'd188 || pkt_count !== 11'd1) begin
      errors++;
      $display("FAIL commit_188: rempty=%b level=%0d pkt=%0d, expected 0,188,1",
               rempty, level, pkt_count);
    end
    read_check("read_188", 188, 188, 0, 0);
    checks++;
    if (rempty !== 1'b1 || level !== 11'd0 || pkt_count !== 11'd0) begin
      errors++;
      $display("FAIL drained: rempty=%b level=%0d pkt=%0d, expected 1,0,0",
               rempty, level, pkt_count);
    end
  endtask

  task automatic test_drop();
    write_pkt(100, 1, 1'b0);
    wdrop = 1'b1;
    tick();
    wdrop = 1'b0;
    checks++;
    if (drop_pulse !== 1'b1 || level !== 11'd0 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL drop_now: drop=%b level=%0d rempty=%b, expected 1,0,1",
               drop_pulse, level, rempty);
    end
    tick();
    checks++;
    if (drop_pulse !== 1'b0 || wafull !== 1'b0 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL drop_after: drop=%b wafull=%b rempty=%b, expected 0,0,1",
               drop_pulse, wafull, rempty);
    end
    write_pkt(188, 1, 1'b1);
    checks++;
    if (level !== 11'd188 || pkt_count !== 11'd1) begin
      errors++;
      $display("FAIL post_drop_commit: level=%0d pkt=%0d, expected 188,1", level, pkt_count);
    end
    read_check("post_drop_read", 188, 188, 1, 0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 20; i++) begin
      s_wen = 1'b1; s_wdata = pat(2, i); s_wlast = (i == 19);
      tick();
      if (i == 10) begin
        checks++;
        if (s_wfull !== 1'b0 || s_wafull !== 1'b0) begin
          errors++;
          $display("FAIL small_11: wfull=%b wafull=%b, expected 0,0", s_wfull, s_wafull);
        end
      end
      if (i == 14) begin
        checks++;
        if (s_wfull !== 1'b0 || s_wafull !== 1'b1) begin
          errors++;
          $display("FAIL small_15: wfull=%b wafull=%b, expected 0,1", s_wfull, s_wafull);
        end
      end
      if (i == 15) begin
        checks++;
        if (s_wfull !== 1'b1 || s_rempty !== 1'b1) begin
          errors++;
          $display("FAIL small_full: wfull=%b rempty=%b, expected 1,1", s_wfull, s_rempty);
        end
      end
    end
    s_wen = 1'b0; s_wlast = 1'b0;
    checks++;
    if (s_drop !== 1'b1 || s_level !== 5'd0 || s_rempty !== 1'b1 ||
        s_wfull !== 1'b0 || s_pkt_count !== 5'd0) begin
      errors++;
      $display("FAIL overflow_rollback: drop=%b level=%0d rempty=%b wfull=%b pkt=%0d, expected 1,0,1,0,0",
               s_drop, s_level, s_rempty, s_wfull, s_pkt_count);
    end
    // Error state must be cleared so the next packet commits
    for (int i = 0; i < 4; i++) begin
      s_wen = 1'b1; s_wdata = pat(2, i); s_wlast = (i == 3);
      tick();
    end
    s_wen = 1'b0; s_wlast = 1'b0;
    checks++;
    if (s_drop !== 1'b0 || s_level !== 5'd4 || s_pkt_count !== 5'd1) begin
      errors++;
      $display("FAIL overflow_recover: drop=%b level=%0d pkt=%0d, expected 0,4,1",
               s_drop, s_level, s_pkt_count);
    end
  endtask

  task automatic test_commit_read_overlap();
    write_pkt(188, 2, 1'b1);
    write_pkt(188, 2, 1'b1);
    write_pkt(187, 2, 1'b0);
    checks++;
    if (pkt_count !== 11'd2 || level !== 11'd376) begin
      errors++;
      $display("FAIL two_pkts: pkt=%0d level=%0d, expected 2,376", pkt_count, level);
    end
    read_check("overlap_head", 187, 188, 2, 0);
    wen = 1'b1; wdata = pat(2, 187); wlast = 1'b1; ren = 1'b1;
    tick();
    wen = 1'b0; wlast = 1'b0; ren = 1'b0;
    checks++;
    if (pkt_count !== 11'd2 || level !== 11'd376 || rlast !== 1'b1 ||
        rdata !== pat(2, 187)) begin
      errors++;
      $display("FAIL overlap: pkt=%0d level=%0d rlast=%b rdata=%h, expected 2,376,1,%h",
               pkt_count, level, rlast, rdata, pat(2, 187));
    end
    read_check("overlap_drain", 376, 188, 2, 0);
    checks++;
    if (pkt_count !== 11'd0 || rempty !== 1'b1) begin
      errors++;
      $display("FAIL overlap_drained: pkt=%0d rempty=%b, expected 0,1", pkt_count, rempty);
    end
  endtask

  task automatic test_streaming();
    bit go_read;
    int wk, rk, maxlvl, guard;
    go_read = 1'b0; wk = 0; rk = 0; maxlvl = 0; guard = 0;
    fork
      begin : writer
        for (int pk = 0; pk < 20; pk++) begin
          if (pk == 4) begin
            checks++;
            if (wafull !== 1'b0) begin
              errors++;
              $display("FAIL wafull_752: wafull=%b, expected 0", wafull);
            end
          end
          if (pk == 5) begin
            checks++;
            if (wafull !== 1'b1) begin
              errors++;
              $display("FAIL wafull_940: wafull=%b, expected 1", wafull);
            end
            go_read = 1'b1;
          end
          for (int i = 0; i < 188; i++) begin
            while (wfull && guard < 40000) begin
              wen = 1'b0;
              tick();
              guard++;
            end
            wen = 1'b1; wdata = stream_byte(wk); wlast = (i == 187);
            tick();
            guard++;
            wk++;
          end
        end
        wen = 1'b0; wlast = 1'b0;
        go_read = 1'b1;
      end
      begin : reader
        int cyc;
        cyc = 0;
        while (!go_read && cyc < 40000) begin
          tick();
          cyc++;
        end
        ren = 1'b1;
        while (rk < 3760 && cyc < 40000) begin
          tick();
          cyc++;
          if (int'(level) > maxlvl) maxlvl = int'(level);
          if (rvalid) begin
            checks++;
            if (rdata !== stream_byte(rk) || rlast !== ((rk % 188) == 187)) begin
              errors++;
              $display("FAIL stream byte %0d: rdata=%h rlast=%b, expected %h %b",
                       rk, rdata, rlast, stream_byte(rk), ((rk % 188) == 187));
            end
            rk++;
          end
        end
        ren = 1'b0;
      end
    join
    checks++;
    if (rk != 3760 || maxlvl > 1024 || maxlvl < 940) begin
      errors++;
      $display("FAIL stream_summary: bytes_read=%0d max_level=%0d, expected 3760 and 940..1024",
               rk, maxlvl);
    end
    tick();
    checks++;
    if (rempty !== 1'b1 || pkt_count !== 11'd0 || level !== 11'd0) begin
      errors++;
      $display("FAIL stream_drained: rempty=%b pkt=%0d level=%0d, expected 1,0,0",
               rempty, pkt_count, level);
    end
  endtask

  task automatic test_reset_mid_read();
    write_pkt(10, 1, 1'b1);
    ren = 1'b1;
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== pat(1, 0)) begin
      errors++;
      $display("FAIL pre_reset_read: rvalid=%b rdata=%h, expected 1,%h",
               rvalid, rdata, pat(1, 0));
    end
    #1;
    rst = 1'b1;
    ren = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rdata !== 8'h00 || rlast !== 1'b0 ||
        rempty !== 1'b1 || level !== 11'd0 || pkt_count !== 11'd0 ||
        wfull !== 1'b0 || drop_pulse !== 1'b0 || s_level !== 5'd0) begin
      errors++;
      $display("FAIL async_reset: rvalid=%b rdata=%h rlast=%b rempty=%b level=%0d pkt=%0d wfull=%b drop=%b s_level=%0d, expected 0,00,0,1,0,0,0,0,0",
               rvalid, rdata, rlast, rempty, level, pkt_count, wfull, drop_pulse, s_level);
    end
    tick();
    rst = 1'b0;
    tick();
    write_pkt(5, 2, 1'b1);
    checks++;
    if (level !== 11'd5 || pkt_count !== 11'd1) begin
      errors++;
      $display("FAIL post_reset_write: level=%0d pkt=%0d, expected 5,1", level, pkt_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_drop();
    test_overflow();
    test_commit_read_overlap();
    test_streaming();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
